// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the data memory access controller
// Purpose: controller state encoding, request-kind constants and default bus widths.
// Ports: none (package).
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  // Value of Req_Write for each request kind
  localparam logic REQ_LOAD  = 1'b0;
  localparam logic REQ_STORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    WAIT  = 3'd3,
    CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/mem_clear_sweep.sv
// rtl/mem_clear_sweep.sv - address generator that walks every location once for a memory clear
// Purpose: on start, asserts busy/wr_en for DEPTH cycles while addr steps 0..DEPTH-1.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      begin a sweep (ignored while busy)
//   addr       current sweep address
//   wr_en      write enable for the current address
//   busy       high for the whole sweep
//   last       high in the final sweep cycle
module mem_clear_sweep
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic              busy,
  output logic              last
);

  // One extra bit so DEPTH == 2**ADDR_W is representable without wrapping
  localparam int CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0] cnt;

  assign last  = busy && (cnt == CNT_W'(DEPTH - 1));
  assign addr  = cnt[ADDR_W-1:0];
  assign wr_en = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      if (last) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - initiator side of the data memory interface for the execute stage
// Purpose: accepts load/store requests over valid/ready, drives memory strobes, returns load
//          data after MEM_LATENCY cycles, and runs a hardware clear sweep of the memory.
// Ports:
//   clk, rst                               clock and synchronous active-high reset
//   Req_Valid/Req_Ready                    request handshake
//   Req_Write/Req_Address/Req_Data         request kind, address and store data
//   Resp_Valid/Resp_Data                   load response pulse and held load data
//   Clear_Start/Clear_Busy                 clear sweep control and status
//   Mem_Read/Mem_Write                     memory strobes (mutually exclusive)
//   Mem_Read_Address/Mem_Write_Address     memory addresses
//   Mem_Write_Data/Mem_Read_Data           memory write and read data
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [ADDR_W-1:0] Req_Address,
  input  logic [DATA_W-1:0] Req_Data,
  output logic              Resp_Valid,
  output logic [DATA_W-1:0] Resp_Data,
  input  logic              Clear_Start,
  output logic              Clear_Busy,
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Read_Address,
  output logic [ADDR_W-1:0] Mem_Write_Address,
  output logic [DATA_W-1:0] Mem_Write_Data,
  input  logic [DATA_W-1:0] Mem_Read_Data
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              sweep_start;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_we;
  logic              sweep_busy;
  logic              sweep_last;

  // A pending clear wins over a request, so ready drops as soon as Clear_Start is seen
  assign Req_Ready   = (state == IDLE) && !rst && !Clear_Start;
  assign sweep_start = (state == IDLE) && Clear_Start;

  mem_clear_sweep #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_sweep (
    .clk   (clk),
    .rst   (rst),
    .start (sweep_start),
    .addr  (sweep_addr),
    .wr_en (sweep_we),
    .busy  (sweep_busy),
    .last  (sweep_last)
  );

  // Write port is shared: the sweep owns it while busy, otherwise the latched store does
  assign Clear_Busy        = sweep_busy;
  assign Mem_Write         = wr_q | sweep_we;
  assign Mem_Write_Address = sweep_busy ? sweep_addr : wr_addr_q;
  assign Mem_Write_Data    = sweep_busy ? '0 : wr_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      lat_cnt          <= '0;
      Resp_Valid       <= 1'b0;
      Resp_Data        <= '0;
      Mem_Read         <= 1'b0;
      Mem_Read_Address <= '0;
      wr_q             <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
    end else begin
      // Strobes and the response are single-cycle pulses unless set below
      Resp_Valid <= 1'b0;
      Mem_Read   <= 1'b0;
      wr_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (Clear_Start) begin
            state <= CLEAR;
          end else if (Req_Valid) begin
            if (Req_Write == REQ_STORE) begin
              state     <= WR;
              wr_q      <= 1'b1;
              wr_addr_q <= Req_Address;
              wr_data_q <= Req_Data;
            end else begin
              state            <= RD;
              Mem_Read         <= 1'b1;
              Mem_Read_Address <= Req_Address;
            end
          end
        end
        WR: state <= IDLE;
        RD: begin
          state   <= WAIT;
          lat_cnt <= '0;
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            Resp_Valid <= 1'b1;
            Resp_Data  <= Mem_Read_Data;
            state      <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        CLEAR: if (sweep_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the 8-bit data memory interface: it accepts load/store requests from the datapath over a valid/ready handshake and drives the memory strobes, addresses and write data. It captures returned read data after a fixed latency and provides a hardware clear sweep that zeroes every memory location. It sits between the CPU execute stage and the data memory.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
DEPTH, 256, number of locations swept by a clear (must be <= 2**ADDR_W)
MEM_LATENCY, 1, cycles from the memory sampling Mem_Read to Mem_Read_Data being valid (>= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
Req_Valid  in  1  request present
Req_Ready  out  1  request accepted when Req_Valid and Req_Ready are both high at a clock edge
Req_Write  in  1  1 = store, 0 = load
Req_Address  in  ADDR_W  request address
Req_Data  in  DATA_W  store data
Resp_Valid  out  1  one-cycle pulse, load data valid; no backpressure
Resp_Data  out  DATA_W  load result; held until the next load response
Clear_Start  in  1  starts the clear sweep when sampled in IDLE
Clear_Busy  out  1  high for the whole sweep
Mem_Read  out  1  memory read strobe
Mem_Write  out  1  memory write strobe
Mem_Read_Address  out  ADDR_W
Mem_Write_Address  out  ADDR_W
Mem_Write_Data  out  DATA_W
Mem_Read_Data  in  DATA_W  data returned by memory

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst. Every register updates only on the rising edge of clk.
- Reset: state goes to IDLE. All registered outputs go to 0: Resp_Valid, Resp_Data, Clear_Busy, Mem_Read, Mem_Write, both addresses, Mem_Write_Data. Latency and sweep counters clear to 0.
- Req_Ready is combinational: (state == IDLE) and not rst and not Clear_Start.
- States and transitions:
  - IDLE: Clear_Start has priority and moves to CLEAR. Otherwise an accepted store moves to WR, and an accepted load moves to RD. Address and data are latched at the accept edge.
  - WR (1 cycle): Mem_Write = 1, with the latched address and data. Returns to IDLE. A store produces no response.
  - RD (1 cycle): Mem_Read = 1, with the latched address. Moves to WAIT.
  - WAIT: counts MEM_LATENCY cycles. At the last one, Resp_Data is captured from Mem_Read_Data, Resp_Valid is registered high, and the state moves to IDLE.
  - CLEAR: Mem_Write = 1 and Mem_Write_Data = 0 every cycle. Mem_Write_Address steps 0, 1, ..., DEPTH-1. The sweep counter is ADDR_W+1 bits wide so it does not wrap at DEPTH = 256. Clear_Busy is high for exactly DEPTH cycles, then the state returns to IDLE.
- Load latency: accept at edge E0 gives Resp_Valid high during the cycle after edge E(MEM_LATENCY+1), i.e. MEM_LATENCY+2 cycles after acceptance. Resp_Valid coincides with IDLE, so a back-to-back request can be accepted in the same cycle.
- Mem_Read and Mem_Write are never high together. Each strobe is high only in its own state, and both are 0 in IDLE and WAIT.
- Clear_Start or Req_Valid outside IDLE is ignored: it is not queued and there is no error.
- Reset mid-operation: the transaction or sweep is aborted. No Resp_Valid is produced. Strobes are 0 in the cycle after the reset edge.
- Req_* inputs may change freely after acceptance; only the latched copies are used.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - the state enum (IDLE, WR, RD, WAIT, CLEAR);
  - the REQ_LOAD / REQ_STORE constants;
  - the default ADDR_W and DATA_W.
- One sub-module, mem_clear_sweep: takes start and reset, and outputs the address, the write enable and busy. It owns the ADDR_W+1-bit counter and its terminal-count compare.

Test Plan:
- Reset: hold rst for 2 cycles mid-stream -> all outputs 0 at the following edge; Req_Ready = 1 in the first cycle after release.
- Store then load (MEM_LATENCY = 1, behavioural memory model): store 0xA5 to 0x10 -> exactly one cycle with Mem_Write = 1, Mem_Write_Address = 0x10, Mem_Write_Data = 0xA5, and no Resp_Valid. Then load 0x10 -> Mem_Read for one cycle with address 0x10; Resp_Valid pulses 3 cycles after accept with Resp_Data = 0xA5.
- Back-to-back loads of 0x01 and 0x02, with the second presented during the first's Resp_Valid cycle -> second accepted that cycle; responses arrive in order, 3 cycles apart.
- Clear sweep: Clear_Start for one cycle in IDLE -> 256 consecutive Mem_Write cycles at addresses 0x00..0xFF with data 0x00; Clear_Busy = 1 and Req_Ready = 0 for those 256 cycles. A following load of 0xFF returns 0x00.
- Collisions: Clear_Start and Req_Valid both high in IDLE -> Req_Ready = 0, request not accepted, sweep starts. Req_Valid during WAIT -> ignored until IDLE.
- Reset during WAIT and at sweep address 0x40 -> no Resp_Valid ever, Mem_Write = 0 next cycle, Clear_Busy = 0, state IDLE.
